clock_set_controller: RTL and testbench
=======================================

# clock_set_controller

Front-panel sequencer for the digital clock's time-setting datapath. Converts two debounced push-button levels (mode, increment) into the `select` field-selection code and single-cycle `increment` pulses that drive the clock core. Also provides auto-repeat while the increment button is held, and an inactivity timeout back to run mode. Sits between the button debouncers and the clock core, in the same clock domain.

## Interface
- `HOLD_CYCLES`, 8: cycles `inc_btn` must stay high after the press pulse before auto-repeat starts; must be ≥ 1.
- `REPEAT_CYCLES`, 4: cycles between auto-repeat pulses; must be ≥ 1.
- `TIMEOUT_CYCLES`, 64: consecutive idle cycles in a set state before returning to RUN; must be ≥ 2.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mode_btn`  in  1  debounced mode button level, synchronous to `clk`.
- `inc_btn`  in  1  debounced increment button level, synchronous to `clk`.
- `select`  out  2  field select to clock core: 0 RUN, 1 seconds, 2 minutes, 3 hours.
- `increment`  out  1  one-cycle increment pulse to clock core.
- `setting`  out  1  high whenever `select` ≠ 0.

## Operation
- **States:** RUN (`select` = 0), SET_SEC (1), SET_MIN (2), SET_HOUR (3). Encode the state directly as `select`. `setting` = |`select`.
- **Edge detection:** registered previous values `mode_prev`, `inc_prev`.
  - A rising edge is current = 1 and prev = 0.
- **Mode edge:** RUN→SET_SEC→SET_MIN→SET_HOUR→RUN, wrapping after SET_HOUR.
- **Inc edge in a SET state:** one `increment` pulse, and the hold counter is cleared.
- **Inc in RUN:** ignored; `increment` stays 0.
- **Simultaneous mode and inc edges:** the mode edge wins. The state advances, no pulse is issued, and the hold counter is cleared.
- **Auto-repeat (macro-dependent):** while `inc_btn` stays high in a SET state, the hold counter increments every cycle.
  - A further pulse fires when the counter reaches `HOLD_CYCLES`, then every `REPEAT_CYCLES` after that.
  - Releasing `inc_btn` clears the counter.
- **Timeout:** the idle counter clears on any cycle where `mode_btn` or `inc_btn` is high, and increments otherwise.
  - In a SET state, reaching `TIMEOUT_CYCLES` forces RUN without issuing a pulse.
  - The counter is held at 0 in RUN.
- **Counter widths:** `$clog2(param+1)` bits each, saturating. Counters never wrap.
- **Leaving a SET state** (mode or timeout) clears the hold counter.

## Timing
- **Reset values:** `select` = 0, `increment` = 0, `setting` = 0, counters = 0.
  - `mode_prev` and `inc_prev` reset to 1, so a button held through reset release produces no edge.
- **Latency:** all outputs are registered.
  - A qualifying edge sampled at rising edge k produces `increment` = 1 and the new `select` valid during cycle k..k+1.
  - `increment` drops at k+1.
  - `increment` is never high for two consecutive cycles.
- **Auto-repeat schedule:** for a press edge sampled at edge k and held, pulses appear after edges k, k+`HOLD_CYCLES`, k+`HOLD_CYCLES`+`REPEAT_CYCLES`, and so on.
- **Timeout schedule:** with the last active sample at edge k, `select` becomes 0 after edge k+`TIMEOUT_CYCLES`.
- **Reset mid-operation:** asserting `reset` low forces the reset values immediately, regardless of `clk`. No pulse is in flight after deassertion.

## Configuration
- **`CLOCK_SET_AUTOREPEAT_EN` defined:**
  - Hold counter present.
  - Auto-repeat as described above.
- **`CLOCK_SET_AUTOREPEAT_EN` undefined:**
  - Hold counter and its logic are removed.
  - `HOLD_CYCLES` and `REPEAT_CYCLES` are ignored.
  - Exactly one `increment` pulse per `inc_btn` rising edge in a SET state.
  - All other behaviour is unchanged.

## Test plan
- **Reset/idle:** hold `reset` = 0 for 3 cycles, then release with both buttons low → `select` = 0, `increment` = 0, `setting` = 0. A further 100 cycles of idle leave `select` = 0.
- **Mode cycling:** four 2-cycle `mode_btn` presses, 4 cycles apart → `select` = 1, 2, 3, 0, each valid one cycle after the press sample. `setting` follows `select`. `increment` never asserts.
- **Single increment:** in SET_MIN, `inc_btn` high for 3 cycles → exactly one `increment` pulse, one cycle wide, one cycle after the first high sample.
  - Same stimulus in RUN → no pulse.
- **Auto-repeat (macro defined, HOLD = 8, REPEAT = 4):** in SET_HOUR, hold `inc_btn` for 20 cycles from edge k → pulses after edges k, k+8, k+12, k+16, 4 pulses total.
  - With the macro undefined → 1 pulse.
- **Timeout (TIMEOUT = 64):** enter SET_SEC, last button activity sampled at edge k → `select` = 1 through edge k+63, `select` = 0 after edge k+64, no `increment`.
  - An inc press at k+50 restarts the count.
- **Boundaries:**
  - Mode and inc rising together in SET_SEC → `select` = 2, no pulse.
  - `inc_btn` held across a `reset` pulse → no pulse after reset release.

Source files
------------

// File: rtl/clock_set_controller.sv
// Front-panel time-setting sequencer: mode/increment buttons to select code and increment pulses.
// Define CLOCK_SET_AUTOREPEAT_EN to build the held-button auto-repeat logic.
module clock_set_controller #(
  parameter int HOLD_CYCLES    = 8,
  parameter int REPEAT_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [1:0] select,
  output logic       increment,
  output logic       setting
);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_SEC  = 2'd1,
    SET_MIN  = 2'd2,
    SET_HOUR = 2'd3
  } state_t;

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state_q, state_d;
  logic              mode_prev, inc_prev;
  logic              increment_q, increment_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              mode_rise, inc_rise, in_set, timeout_hit, repeat_fire;

  assign mode_rise   = mode_btn & ~mode_prev;
  assign inc_rise    = inc_btn & ~inc_prev;
  assign in_set      = (state_q != RUN);
  assign timeout_hit = in_set && !mode_btn && !inc_btn &&
                       (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [REP_W-1:0]  rep_q, rep_d;

  // hold_q saturates at HOLD_CYCLES; rep_q then paces the repeat pulses.
  always_comb begin
    hold_d      = hold_q;
    rep_d       = rep_q;
    repeat_fire = 1'b0;
    if (!in_set || !inc_btn || inc_rise || mode_rise || timeout_hit) begin
      hold_d = '0;
      rep_d  = '0;
    end else if (hold_q != HOLD_W'(HOLD_CYCLES)) begin
      hold_d      = hold_q + HOLD_W'(1);
      repeat_fire = (hold_q == HOLD_W'(HOLD_CYCLES - 1));
    end else if (rep_q == REP_W'(REPEAT_CYCLES - 1)) begin
      rep_d       = '0;
      repeat_fire = 1'b1;
    end else begin
      rep_d = rep_q + REP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
      rep_q  <= '0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    increment_d = 1'b0;
    idle_d      = idle_q;

    if (mode_btn || inc_btn || !in_set) begin
      idle_d = '0;
    end else if (idle_q != IDLE_W'(TIMEOUT_CYCLES)) begin
      idle_d = idle_q + IDLE_W'(1);
    end

    // Mode edge wins over any increment activity in the same cycle.
    if (mode_rise) begin
      case (state_q)
        RUN:      state_d = SET_SEC;
        SET_SEC:  state_d = SET_MIN;
        SET_MIN:  state_d = SET_HOUR;
        default:  state_d = RUN;
      endcase
    end else if (in_set) begin
      if (timeout_hit) begin
        state_d = RUN;
        idle_d  = '0;
      end else if (inc_rise || (repeat_fire && !increment_q)) begin
        increment_d = 1'b1;
      end
    end
  end

  // Previous-value registers reset high so a button held through reset is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      mode_prev   <= 1'b1;
      inc_prev    <= 1'b1;
      increment_q <= 1'b0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      mode_prev   <= mode_btn;
      inc_prev    <= inc_btn;
      increment_q <= increment_d;
      idle_q      <= idle_d;
    end
  end

  assign select    = state_q;
  assign increment = increment_q;
  assign setting   = |state_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Self-checking bench for clock_set_controller: queued expected pulse times plus per-scenario select checks.
module tb_clock_set_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [1:0] select;
  logic       increment;
  logic       setting;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];
  logic prev_inc = 1'b0;
  bit mon_en = 1'b0;

  clock_set_controller #(
    .HOLD_CYCLES(8),
    .REPEAT_CYCLES(4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode_btn(mode_btn),
    .inc_btn(inc_btn),
    .select(select),
    .increment(increment),
    .setting(setting)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200us;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // Every observed pulse is matched against the queued expected cycle number.
  always @(negedge clk) begin
    if (mon_en && increment === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected cyc=%0d actual=1 required=0", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL pulse_time actual=%0d required=%0d", cyc, e);
        end
      end
      checks++;
      if (prev_inc === 1'b1) begin
        errors++;
        $display("FAIL pulse_width cyc=%0d actual=2 required=1", cyc);
      end
    end
    prev_inc = increment;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_mode();
    @(negedge clk) mode_btn = 1'b1;
    @(negedge clk);
    @(negedge clk) mode_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    step(3);
    checks++;
    if (select !== 2'd0) begin errors++; $display("FAIL reset_select actual=%0d required=0", select); end
    checks++;
    if (increment !== 1'b0) begin errors++; $display("FAIL reset_increment actual=%b required=0", increment); end
    checks++;
    if (setting !== 1'b0) begin errors++; $display("FAIL reset_setting actual=%b required=0", setting); end
    @(negedge clk) reset = 1'b1;
    mon_en = 1'b1;
    step(1);
    checks++;
    if (select !== 2'd0 || increment !== 1'b0) begin
      errors++; $display("FAIL release_idle actual=%0d/%b required=0/0", select, increment);
    end
    step(100);
    checks++;
    if (select !== 2'd0 || setting !== 1'b0) begin
      errors++; $display("FAIL idle_100 actual=%0d/%b required=0/0", select, setting);
    end
  endtask

  task automatic test_mode_cycling();
    logic [1:0] exp_sel [4];
    exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd3; exp_sel[3] = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) mode_btn = 1'b1;
      @(negedge clk);
      checks++;
      if (select !== exp_sel[i]) begin
        errors++; $display("FAIL mode_select[%0d] actual=%0d required=%0d", i, select, exp_sel[i]);
      end
      checks++;
      if (setting !== (exp_sel[i] != 2'd0)) begin
        errors++; $display("FAIL mode_setting[%0d] actual=%b required=%b", i, setting, exp_sel[i] != 2'd0);
      end
      @(negedge clk) mode_btn = 1'b0;
      checks++;
      if (select !== exp_sel[i]) begin
        errors++; $display("FAIL mode_hold[%0d] actual=%0d required=%0d", i, select, exp_sel[i]);
      end
      step(2);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL mode_pending actual=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_single_inc();
    press_mode();
    press_mode();
    checks++;
    if (select !== 2'd2) begin errors++; $display("FAIL inc_enter_min actual=%0d required=2", select); end
    @(negedge clk) inc_btn = 1'b1;
    exp_q.push_back(cyc + 1);
    step(3);
    inc_btn = 1'b0;
    step(3);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL inc_single_missing actual=%0d required=0", exp_q.size()); end
    press_mode();
    press_mode();
    checks++;
    if (select !== 2'd0) begin errors++; $display("FAIL inc_back_run actual=%0d required=0", select); end
    @(negedge clk) inc_btn = 1'b1;
    step(3);
    inc_btn = 1'b0;
    step(3);
    checks++;
    if (select !== 2'd0 || exp_q.size() != 0) begin
      errors++; $display("FAIL inc_in_run actual=%0d/%0d required=0/0", select, exp_q.size());
    end
  endtask

  task automatic test_autorepeat();
    int k;
    press_mode();
    press_mode();
    press_mode();
    checks++;
    if (select !== 2'd3) begin errors++; $display("FAIL rep_enter_hour actual=%0d required=3", select); end
    @(negedge clk) inc_btn = 1'b1;
    k = cyc + 1;
    exp_q.push_back(k);
`ifdef CLOCK_SET_AUTOREPEAT_EN
    exp_q.push_back(k + 8);
    exp_q.push_back(k + 12);
    exp_q.push_back(k + 16);
`endif
    step(20);
    inc_btn = 1'b0;
    step(4);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rep_missing actual=%0d required=0", exp_q.size()); end
    press_mode();
    checks++;
    if (select !== 2'd0) begin errors++; $display("FAIL rep_back_run actual=%0d required=0", select); end
  endtask

  task automatic test_timeout();
    int k;
    @(negedge clk) mode_btn = 1'b1;
    @(negedge clk);
    @(negedge clk) mode_btn = 1'b0;
    k = cyc;
    while (cyc < k + 63) @(negedge clk);
    checks++;
    if (select !== 2'd1) begin errors++; $display("FAIL tmo_before actual=%0d required=1", select); end
    @(negedge clk);
    checks++;
    if (select !== 2'd0 || setting !== 1'b0) begin
      errors++; $display("FAIL tmo_expire actual=%0d/%b required=0/0", select, setting);
    end
    @(negedge clk) mode_btn = 1'b1;
    @(negedge clk);
    @(negedge clk) mode_btn = 1'b0;
    k = cyc;
    while (cyc < k + 49) @(negedge clk);
    inc_btn = 1'b1;
    exp_q.push_back(cyc + 1);
    @(negedge clk) inc_btn = 1'b0;
    while (cyc < k + 64) @(negedge clk);
    checks++;
    if (select !== 2'd1) begin errors++; $display("FAIL tmo_restart actual=%0d required=1", select); end
    while (cyc < k + 113) @(negedge clk);
    checks++;
    if (select !== 2'd1) begin errors++; $display("FAIL tmo_restart_before actual=%0d required=1", select); end
    @(negedge clk);
    checks++;
    if (select !== 2'd0) begin errors++; $display("FAIL tmo_restart_expire actual=%0d required=0", select); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL tmo_pending actual=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_boundaries();
    press_mode();
    @(negedge clk) begin mode_btn = 1'b1; inc_btn = 1'b1; end
    @(negedge clk);
    checks++;
    if (select !== 2'd2) begin errors++; $display("FAIL both_edges_select actual=%0d required=2", select); end
    @(negedge clk) begin mode_btn = 1'b0; inc_btn = 1'b0; end
    step(3);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL both_edges_pending actual=%0d required=0", exp_q.size()); end
    press_mode();
    press_mode();
    checks++;
    if (select !== 2'd0) begin errors++; $display("FAIL bnd_back_run actual=%0d required=0", select); end

    press_mode();
    @(negedge clk) inc_btn = 1'b1;
    exp_q.push_back(cyc + 1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    mode_btn = 1'b1;
    #1;
    checks++;
    if (select !== 2'd0 || increment !== 1'b0) begin
      errors++; $display("FAIL async_reset actual=%0d/%b required=0/0", select, increment);
    end
    step(2);
    @(negedge clk) reset = 1'b1;
    step(5);
    checks++;
    if (select !== 2'd0 || exp_q.size() != 0) begin
      errors++; $display("FAIL held_through_reset actual=%0d/%0d required=0/0", select, exp_q.size());
    end
    mode_btn = 1'b0;
    inc_btn = 1'b0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_mode_cycling();
    test_single_inc();
    test_autorepeat();
    test_timeout();
    test_boundaries();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
